// File: rtl/fetch_control.sv
// Program-counter sequencing FSM: issues instruction/data memory enables, holds
// the PC while memory is busy, and halts on a decoded halt or a wait timeout.
module fetch_control #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dren,
   input  logic             dwen,
   input  logic             halt,
   output logic             pcenable,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      MEM   = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

   state_t      state, state_n;
   logic [15:0] wait_cnt, wait_cnt_n;
   logic        req_rd, req_rd_n;
   logic        req_wr, req_wr_n;
   logic        waiting;
   logic        to_timeout;
   logic        stall_inc;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         req_rd      <= 1'b0;
         req_wr      <= 1'b0;
         stall_cnt   <= '0;
         halted      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         wait_cnt    <= wait_cnt_n;
         req_rd      <= req_rd_n;
         req_wr      <= req_wr_n;
         halted      <= halted | (state_n == HALT);
         timeout_err <= timeout_err | to_timeout;
         if (stall_inc)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // Outputs decode from the registered state so reset clears them at once.
   always_comb begin
      state_n    = state;
      req_rd_n   = req_rd;
      req_wr_n   = req_wr;
      pcenable   = 1'b0;
      imemREN    = 1'b0;
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      waiting    = 1'b0;
      to_timeout = 1'b0;
      case (state)
         IDLE: state_n = FETCH;
         FETCH: begin
            imemREN = 1'b1;
            if (ihit) begin
               if (halt) begin
                  state_n = HALT;
               end else if (dren | dwen) begin
                  state_n  = MEM;
                  req_wr_n = dwen;
                  req_rd_n = dren & ~dwen;
               end else begin
                  pcenable = 1'b1;
               end
            end else begin
               waiting = 1'b1;
               if (wait_cnt == WAIT_LIMIT) begin
                  state_n    = HALT;
                  to_timeout = 1'b1;
               end
            end
         end
         MEM: begin
            dmemREN = req_rd;
            dmemWEN = req_wr;
            if (dhit) begin
               pcenable = 1'b1;
               state_n  = FETCH;
            end else begin
               waiting = 1'b1;
               if (wait_cnt == WAIT_LIMIT) begin
                  state_n    = HALT;
                  to_timeout = 1'b1;
               end
            end
         end
         HALT: state_n = HALT;
         default: state_n = IDLE;
      endcase
   end

   // Watchdog restarts on any state change or hit; it never exceeds WAIT_LIMIT.
   always_comb begin
      wait_cnt_n = '0;
      if (state_n == state && waiting)
         wait_cnt_n = wait_cnt + 16'd1;
   end

   assign stall_inc = ((state == FETCH) || (state == MEM)) && !pcenable &&
                      (stall_cnt != {CNT_W{1'b1}});
   assign state_dbg = state;

endmodule
